simmem_delay_releaser: RTL

// Per-internal-ID release timer placed directly upstream of simmem_resp_banks, on one response

---
 rtl/simmem_pkg.sv | 12 +
 rtl/simmem_delay_slot.sv | 46 ++++
 rtl/simmem_delay_releaser.sv | 104 ++++++++++
 3 files changed

// File: rtl/simmem_pkg.sv
// Shared types and constants for the simulated-memory response path.
//   DelayW      : width of a release delay in cycles
//   delay_t     : delay field type
//   DefCapacity : default number of tracked internal IDs
package simmem_pkg;

  localparam int unsigned DelayW      = 8;
  localparam int unsigned DefCapacity = 16;

  typedef logic [DelayW-1:0] delay_t;

endpackage : simmem_pkg

// File: rtl/simmem_delay_slot.sv
// One release-timer entry: holds valid/count, arms, counts down, retires.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   arm_i         : load delay_i and mark valid (wins over retire_i)
//   delay_i       : cycles to wait before release
//   retire_i      : clear the entry
//   valid_o       : entry is armed
//   release_en_o  : entry is armed and its count has expired
module simmem_delay_slot
  import simmem_pkg::*;
#(
  parameter int unsigned DelayWidth = DelayW
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  arm_i,
  input  logic [DelayWidth-1:0] delay_i,
  input  logic                  retire_i,
  output logic                  valid_o,
  output logic                  release_en_o
);

  logic                  valid_q;
  logic [DelayWidth-1:0] cnt_q;

  // Arm has priority over retire; the count saturates at zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else if (arm_i) begin
      valid_q <= 1'b1;
      cnt_q   <= delay_i;
    end else begin
      if (retire_i) begin
        valid_q <= 1'b0;
      end
      if (valid_q && (cnt_q != '0)) begin
        cnt_q <= cnt_q - DelayWidth'(1);
      end
    end
  end

  assign valid_o      = valid_q;
  assign release_en_o = valid_q && (cnt_q == '0);

endmodule : simmem_delay_slot

// File: rtl/simmem_delay_releaser.sv
// Per-internal-ID release timer feeding the response bank's release enables.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   in_iid_i/in_delay_i     : entry to arm and its delay
//   in_valid_i/in_ready_o   : arm handshake (ready is combinational)
//   release_en_o            : multi-hot release enable to the bank
//   released_addr_onehot_i  : retire strobe from the bank
//   occupancy_o             : registered count of armed entries
module simmem_delay_releaser
  import simmem_pkg::*;
#(
  parameter int unsigned Capacity   = DefCapacity,
  parameter int unsigned IidWidth   = $clog2(Capacity),
  parameter int unsigned DelayWidth = DelayW
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [IidWidth-1:0]   in_iid_i,
  input  logic [DelayWidth-1:0] in_delay_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [Capacity-1:0]   release_en_o,
  input  logic [Capacity-1:0]   released_addr_onehot_i,
  output logic [IidWidth:0]     occupancy_o
);

  localparam int unsigned OccW = IidWidth + 1;

  logic [Capacity-1:0] valid;
  logic [Capacity-1:0] arm;
  logic [Capacity-1:0] valid_next;
  logic                sel_valid;
  logic                sel_retire;
  logic [OccW-1:0]     occ_d;
  logic [OccW-1:0]     occ_q;

  // Select the addressed entry's state; out-of-range ids select nothing.
  always_comb begin
    sel_valid  = 1'b0;
    sel_retire = 1'b0;
    for (int unsigned i = 0; i < Capacity; i++) begin
      if (32'(in_iid_i) == i) begin
        sel_valid  = valid[i];
        sel_retire = released_addr_onehot_i[i];
      end
    end
  end

  // An armed entry is never overwritten unless it retires this cycle.
  assign in_ready_o = !rst_i && (!sel_valid || sel_retire);

  // Decode the accepted arm to a per-slot strobe.
  always_comb begin
    arm = '0;
    for (int unsigned i = 0; i < Capacity; i++) begin
      arm[i] = in_valid_i && in_ready_o && (32'(in_iid_i) == i);
    end
  end

  for (genvar g = 0; g < Capacity; g++) begin : g_slot
    simmem_delay_slot #(
      .DelayWidth (DelayWidth)
    ) u_slot (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .arm_i        (arm[g]),
      .delay_i      (in_delay_i),
      .retire_i     (released_addr_onehot_i[g]),
      .valid_o      (valid[g]),
      .release_en_o (release_en_o[g])
    );
  end

  // Popcount of the slots' next valid state so occupancy moves with valid_q.
  always_comb begin
    occ_d = '0;
    for (int unsigned i = 0; i < Capacity; i++) begin
      valid_next[i] = arm[i] || (valid[i] && !released_addr_onehot_i[i]);
      occ_d         = occ_d + OccW'(valid_next[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy_o = occ_q;

  a_retire_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(released_addr_onehot_i));

  a_iid_in_range : assert property (@(posedge clk_i) disable iff (rst_i)
    in_valid_i |-> (32'(in_iid_i) < Capacity));

  a_release_subset : assert property (@(posedge clk_i)
    (release_en_o & ~valid) == '0);

  a_retire_valid : assert property (@(posedge clk_i) disable iff (rst_i)
    (released_addr_onehot_i & ~valid) == '0);

endmodule : simmem_delay_releaser
